// File: rtl/pipe_pkg.sv
// Shared types and default link widths for the core's valid/ready stage buffers.
// Optional build macro used by pipe_stage_buf: PIPE_STAGE_PERF_EN.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } slot_state_t;

   localparam int IF2ID_W = 64;
   localparam int ID2EX_W = 192;
   localparam int EX2LS_W = 109;
   localparam int LS2WB_W = 104;

   // Number of beats a slot holds in a given state.
   function automatic logic [1:0] slot_occ(input slot_state_t s);
      logic [1:0] occ;
      case (s)
         EMPTY:   occ = 2'd0;
         ONE:     occ = 2'd1;
         TWO:     occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_stage_buf_skid_slot.sv
// One skid slot: a main register plus a skid register, with in_ready and out_valid
// taken straight from flops so no ready path runs combinationally through the slot.
module skid_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occ_d
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              in_fire_s, out_fire_s;

   assign in_fire_s  = in_valid && in_ready_q;
   assign out_fire_s = out_valid_q && out_ready;

   // State, payload and handshake flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         main_q      <= {DATA_W{1'b0}};
         skid_q      <= {DATA_W{1'b0}};
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next state and payload movement; flush empties the slot but leaves data alone.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire_s) begin
                  state_d = ONE;
                  main_d  = in_data;
               end else begin
                  state_d = EMPTY;
               end
            end
            ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_d = in_data;
               end else if (in_fire_s) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (out_fire_s) begin
                  state_d = EMPTY;
               end else begin
                  state_d = ONE;
               end
            end
            TWO: begin
               if (out_fire_s) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = TWO;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Handshake outputs are decoded from the next state and registered.
   always_comb begin
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
      occ_d       = slot_occ(state_d);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Chain of STAGES skid slots with synchronous flush and a registered occupancy count.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt / bubble_cnt performance counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int STAGES = 1,
   parameter int CNT_W  = $clog2(2 * STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt,
`endif
   output logic [CNT_W-1:0]  count
);

   logic              vld_s [STAGES+1];
   logic              rdy_s [STAGES+1];
   logic [DATA_W-1:0] dat_s [STAGES+1];
   logic [1:0]        occ_s [STAGES];
   logic [CNT_W-1:0]  count_q, count_d;

   assign vld_s[0]      = in_valid;
   assign dat_s[0]      = in_data;
   assign rdy_s[STAGES] = out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      skid_slot #(.DATA_W(DATA_W)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (vld_s[k]),
         .in_data   (dat_s[k]),
         .in_ready  (rdy_s[k]),
         .out_valid (vld_s[k+1]),
         .out_data  (dat_s[k+1]),
         .out_ready (rdy_s[k+1]),
         .occ_d     (occ_s[k])
      );
   end

   assign in_ready  = rdy_s[0];
   assign out_valid = vld_s[STAGES];
   assign out_data  = dat_s[STAGES];

   // Occupancy is summed from each slot's next state so the flop tracks the slots exactly.
   always_comb begin
      count_d = {CNT_W{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
         count_d = count_d + CNT_W'(occ_s[k]);
      end
   end

   // Occupancy count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] bubble_q, bubble_d;

   // Counters wrap naturally and survive flush.
   always_comb begin
      stall_d  = (out_valid && !out_ready) ? stall_q + 32'd1 : stall_q;
      bubble_d = (in_valid && !in_ready) ? bubble_q + 32'd1 : bubble_q;
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q  <= 32'd0;
         bubble_q <= 32'd0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a one-slot and a two-slot instance share stimulus and are
// checked every cycle against a queue-per-slot model, plus hand-computed expectations.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        out_ready = 1'b0;

   logic        in_ready1, out_valid1, in_ready2, out_valid2;
   logic [31:0] out_data1, out_data2;
   logic [1:0]  count1;
   logic [2:0]  count2;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall1, bubble1, stall2, bubble2;
   int unsigned mstall [2];
   int unsigned mbubble [2];
`endif

   int n_cmp = 0;
   int n_fail = 0;

   // model: per instance, per slot, a small FIFO of up to two beats
   int          mn [2][2];
   logic [31:0] md [2][2][2];
   bit          men;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(32), .STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_EN
      .stall_cnt(stall1), .bubble_cnt(bubble1),
`endif
      .count(count1)
   );

   pipe_stage_buf #(.DATA_W(32), .STAGES(2)) u_s2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
`ifdef PIPE_STAGE_PERF_EN
      .stall_cnt(stall2), .bubble_cnt(bubble2),
`endif
      .count(count2)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 2; k++) mn[m][k] = 0;
`ifdef PIPE_STAGE_PERF_EN
         mstall[m]  = 0;
         mbubble[m] = 0;
`endif
      end
      men = 1'b0;
   endtask

   // Advance the model across one rising edge using the pre-edge inputs.
   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int          s;
         bit          rdy [3];
         bit          ifire [2];
         bit          ofire [2];
         logic [31:0] ind [2];
         s = m + 1;
         for (int k = 0; k < 3; k++) rdy[k] = 1'b0;
         for (int k = 0; k < 2; k++) begin
            ifire[k] = 1'b0;
            ofire[k] = 1'b0;
            ind[k]   = 32'd0;
         end
         for (int k = 0; k < s; k++) rdy[k] = men && (mn[m][k] < 2);
         rdy[s] = out_ready;
         for (int k = 0; k < s; k++) begin
            bit uv;
            uv     = (k == 0) ? in_valid : (mn[m][k-1] > 0);
            ind[k] = (k == 0) ? in_data : md[m][k-1][0];
            ifire[k] = uv && rdy[k];
            ofire[k] = (mn[m][k] > 0) && rdy[k+1];
         end
`ifdef PIPE_STAGE_PERF_EN
         if (mn[m][s-1] > 0 && !out_ready) mstall[m]++;
         if (in_valid && !rdy[0]) mbubble[m]++;
`endif
         if (flush) begin
            for (int k = 0; k < 2; k++) mn[m][k] = 0;
         end else begin
            for (int k = 0; k < s; k++) begin
               if (ofire[k]) begin
                  md[m][k][0] = md[m][k][1];
                  mn[m][k]--;
               end
               if (ifire[k]) begin
                  md[m][k][mn[m][k]] = ind[k];
                  mn[m][k]++;
               end
            end
         end
      end
      men = 1'b1;
   endtask

   task automatic check_one(input int m, input logic ir, input logic ov, input logic [31:0] od,
                            input logic [2:0] cnt);
      int s;
      int tot;
      s   = m + 1;
      tot = 0;
      for (int k = 0; k < s; k++) tot += mn[m][k];
      chk($sformatf("s%0d_in_ready", s), {63'd0, ir}, {63'd0, (men && mn[m][0] < 2)});
      chk($sformatf("s%0d_out_valid", s), {63'd0, ov}, {63'd0, (mn[m][s-1] > 0)});
      chk($sformatf("s%0d_count", s), {61'd0, cnt}, 64'(tot));
      if (mn[m][s-1] > 0) chk($sformatf("s%0d_out_data", s), {32'd0, od}, {32'd0, md[m][s-1][0]});
   endtask

   task automatic check_all();
      check_one(0, in_ready1, out_valid1, out_data1, {1'b0, count1});
      check_one(1, in_ready2, out_valid2, out_data2, count2);
`ifdef PIPE_STAGE_PERF_EN
      chk("s1_stall", {32'd0, stall1}, {32'd0, mstall[0]});
      chk("s1_bubble", {32'd0, bubble1}, {32'd0, mbubble[0]});
      chk("s2_stall", {32'd0, stall2}, {32'd0, mstall[1]});
      chk("s2_bubble", {32'd0, bubble2}, {32'd0, mbubble[1]});
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] d;
      model_reset();
      #12;
      // reset values while held
      chk("rst_out_valid", {63'd0, out_valid2}, 64'd0);
      chk("rst_out_data", {32'd0, out_data2}, 64'd0);
      chk("rst_count", {61'd0, count2}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready2}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_in_ready_low", {63'd0, in_ready1}, 64'd0);
      @(negedge clk);
      cycle();
      chk("rel_in_ready_high", {63'd0, in_ready2}, 64'd1);

      // single beat through two slots
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      cycle();
      in_valid = 1'b0;
      chk("single_not_yet", {63'd0, out_valid2}, 64'd0);
      cycle();
      chk("single_valid", {63'd0, out_valid2}, 64'd1);
      chk("single_data", {32'd0, out_data2}, 64'hDEADBEEF);
      cycle();
      chk("single_count0", {61'd0, count2}, 64'd0);
      cycle();

      // streaming 0..15 with no bubbles
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         cycle();
         chk("stream_in_ready", {63'd0, in_ready1}, 64'd1);
         chk("stream_out_valid", {63'd0, out_valid1}, 64'd1);
         chk("stream_out_data", {32'd0, out_data1}, 64'(i));
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle();

      // backpressure fill of the two-slot chain
      out_ready = 1'b0;
      in_valid  = 1'b1;
      d         = 32'd100;
      for (int i = 0; i < 6; i++) begin
         in_data = d;
         if (in_ready2) d = d + 32'd1;
         cycle();
      end
      chk("bp_count4", {61'd0, count2}, 64'd4);
      chk("bp_in_ready0", {63'd0, in_ready2}, 64'd0);
      chk("bp_count_s1", {62'd0, count1}, 64'd2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk("bp_drain_data", {32'd0, out_data2}, 64'(100 + j));
         cycle();
         if (j == 0) chk("bp_ready_still0", {63'd0, in_ready2}, 64'd0);
         if (j == 1) chk("bp_ready_back", {63'd0, in_ready2}, 64'd1);
      end
      for (int i = 0; i < 2; i++) cycle();

      // flush with three beats held and a beat presented on the flush cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h0000_0A00 + 32'(i);
         cycle();
      end
      chk("fl_count3", {61'd0, count2}, 64'd3);
      flush   = 1'b1;
      in_data = 32'h0000_0BAD;
      cycle();
      chk("fl_count0", {61'd0, count2}, 64'd0);
      chk("fl_out_valid0", {63'd0, out_valid2}, 64'd0);
      chk("fl_count0_s1", {62'd0, count1}, 64'd0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("fl_no_output", {63'd0, out_valid2}, 64'd0);
      end

      // async reset between edges
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h0000_0C00 + 32'(i);
         cycle();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("ar_out_valid", {63'd0, out_valid2}, 64'd0);
      chk("ar_count", {61'd0, count2}, 64'd0);
      chk("ar_count_s1", {62'd0, count1}, 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      cycle();
      chk("ar_in_ready", {63'd0, in_ready2}, 64'd1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h12345678;
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("ar_first_valid", {63'd0, out_valid2}, 64'd1);
      chk("ar_first_data", {32'd0, out_data2}, 64'h12345678);
      cycle();

`ifdef PIPE_STAGE_PERF_EN
      begin
         int unsigned base;
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_data   = 32'h0000_0D00;
         cycle();
         in_valid = 1'b0;
         cycle();
         base = mstall[1];
         for (int i = 0; i < 10; i++) cycle();
         chk("perf_stall10", {32'd0, stall2 - base}, 64'd10);
         in_valid = 1'b1;
         for (int i = 0; i < 3; i++) begin
            in_data = 32'h0000_0D01 + 32'(i);
            cycle();
         end
         chk("perf_full", {63'd0, in_ready2}, 64'd0);
         base = mbubble[1];
         for (int i = 0; i < 5; i++) cycle();
         chk("perf_bubble5", {32'd0, bubble2 - base}, 64'd5);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         for (int i = 0; i < 5; i++) cycle();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised valid/ready pipeline stage buffer for inter-stage links in the five-stage core: IFU→IDU, IDU→EXU, EXU→LSU, LSU→WBU.
- Chains STAGES identical skid slots. Full throughput at one beat per cycle; every slot's in_ready is registered, so there is no combinational ready path between stages.
- Adds a synchronous flush for branch and jump redirect, which the current point-to-point stage handshakes lack.

Parameters:
- DATA_W, 64: payload width in bits (≥1).
- STAGES, 1: number of chained skid slots (≥1). Minimum latency is STAGES cycles.
- CNT_W, $clog2(2*STAGES+1): width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- flush  in  1  synchronous kill of all buffered beats.
- in_valid  in  1  upstream beat valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  buffer can accept a beat this cycle.
- out_valid  out  1  downstream beat valid.
- out_data  out  DATA_W  downstream payload.
- out_ready  in  1  downstream accepts.
- count  out  CNT_W  total beats currently held.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (while rst=0 and on release): all slots EMPTY, all data registers 0, out_valid=0, out_data=0, count=0, in_ready=0. in_ready rises to 1 on the first cycle after release.
- Handshake:
  - A beat transfers on a rising edge when valid && ready.
  - valid must not depend on ready. Once asserted, valid and data stay stable until the beat transfers, except when flush is asserted.
- Slot state machine (per slot; holds a main reg and a skid reg):
  - EMPTY: in fire → ONE, data loads into main.
  - ONE: in fire & out fire → ONE, main replaced. In fire only → TWO, data loads into skid. Out fire only → EMPTY.
  - TWO: slot in_ready=0. Out fire → ONE, skid moves to main. TWO is never entered from TWO.
  - Slot in_ready = !(state==TWO), a registered-state decode only. Slot out_valid = (state!=EMPTY). Slot out_data = main.
- Chaining:
  - Slot k's output connects to slot k+1's input.
  - Top in_ready comes from slot 0; out_valid and out_data come from slot STAGES-1.
- Latency and throughput:
  - A beat entering an empty chain appears on out_valid exactly STAGES cycles after acceptance.
  - With out_ready held at 1, one beat per cycle is sustained with no bubbles.
- Capacity: 2*STAGES beats. count = sum of slot occupancies (0/1/2), registered, updated every edge.
- Flush:
  - flush=1 at an edge sets every slot to EMPTY and count to 0 for the next cycle.
  - It overrides any simultaneous in or out fire. A beat presented with flush is discarded, whether or not in_ready was high.
  - out_fire with flush is still seen by downstream in that cycle. Downstream must qualify it with its own flush.
  - Data registers are not cleared by flush.
- Reset mid-operation: immediate asynchronous clear to the reset values; in-flight beats are lost.
- Backpressure: with out_ready=0 the chain fills. in_ready drops the cycle after slot 0 reaches TWO.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: adds two outputs, each 32 bits, reset 0, wrapping at 2^32, not cleared by flush.
  - stall_cnt counts cycles where out_valid && !out_ready.
  - bubble_cnt counts cycles where in_valid && !in_ready.
- Undefined: the ports and counters do not exist, and there is zero area cost.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] slot_state_t {EMPTY, ONE, TWO}.
  - Localparam default payload widths per link: IF2ID_W=64, ID2EX_W=192, EX2LS_W=109, LS2WB_W=104.
- One sub-module, skid_slot: one slot plus its state machine, instantiated STAGES times with a generate loop. The top handles chaining, count, and the optional counters.

Test Plan:
- Single beat, STAGES=2, DATA_W=32: push 0xDEADBEEF with out_ready=1 → out_valid high 2 cycles later with out_data=0xDEADBEEF, count returns to 0.
- Streaming: 16 consecutive beats 0..15, out_ready=1, STAGES=1 → outputs 0..15 in order on 16 consecutive cycles, in_ready never drops.
- Backpressure, STAGES=2: out_ready=0, push continuously → exactly 4 beats accepted, count=4, in_ready=0. Then out_ready=1 → beats drain in order and in_ready returns the cycle after slot 0 leaves TWO.
- Flush, chain holding 3 beats, in_valid=1 on the flush cycle → next cycle count=0, out_valid=0, the flush-cycle beat is never output.
- Async reset mid-stream: assert rst=0 between clock edges → out_valid and count go to 0 immediately, without waiting for a clock edge. After release, in_ready=1 and the first new beat is output correctly.
- PIPE_STAGE_PERF_EN: hold out_ready=0 for 10 cycles with one beat held → stall_cnt=10. Keep pushing while full for 5 cycles → bubble_cnt=5.
